// File: rtl/frogger_pkg.sv
// Shared types and helpers for the frogger game-state logic.
package frogger_pkg;

  typedef enum logic [2:0] {ALIVE, DYING, SCORED, WON, LOST} state_t;

  localparam int NUM_SLOTS_DEF      = 5;
  localparam int LIVES_DEF          = 3;
  localparam int RESPAWN_FRAMES_DEF = 60;

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int cnt_w(input int maxval);
    int w;
    w = $clog2(maxval + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Counts frame ticks while enabled; done fires on the tick that reaches TERM,
// and the count wraps to zero on that same edge.
module frame_counter
  import frogger_pkg::*;
#(
  parameter int TERM = RESPAWN_FRAMES_DEF,
  parameter int W    = cnt_w(TERM)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         done
);

  assign done = en & tick & (count == W'(TERM - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)      count <= '0;
    else if (en && tick) count <= done ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/frog_collision_fsm.sv
// Frog collision and game-state controller: pixel collision detect, lives,
// pond slots, death/respawn sequencing. Optional life timer: FROG_TIMER_EN.
module frog_collision_fsm
  import frogger_pkg::*;
#(
  parameter int NUM_HAZ        = 115,
  parameter int NUM_SLOTS      = NUM_SLOTS_DEF,
  parameter int LIVES          = LIVES_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter int TIME_FRAMES    = 1800
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic                        frog,
  input  logic                        border,
  input  logic [NUM_HAZ-1:0]          traffic,
  input  logic [NUM_SLOTS-1:0]        end_zone,
  output logic                        win,
  output logic                        game_over,
  output logic                        hit,
  output logic                        score_pulse,
  output logic                        respawn,
  output logic [cnt_w(LIVES)-1:0]     lives,
  output logic [NUM_SLOTS-1:0]        slots_filled
`ifdef FROG_TIMER_EN
  ,
  output logic [cnt_w(TIME_FRAMES)-1:0] time_left
`endif
);

  localparam int LW = cnt_w(LIVES);

  state_t               state, state_n;
  logic [LW-1:0]        lives_n;
  logic [NUM_SLOTS-1:0] slots_n, open_vec, low_slot;
  logic                 hit_n, score_n, resp_n;
  logic                 squish, open_hit, dup_hit, death;
  logic                 dly_en, dly_done;
  logic [cnt_w(RESPAWN_FRAMES)-1:0] unused_dly_cnt;

  assign squish   = frog & (border | (|traffic));
  assign open_vec = end_zone & ~slots_filled;
  // Isolate the lowest set bit: only one slot is claimed per landing.
  assign low_slot = open_vec & (~open_vec + NUM_SLOTS'(1));
  assign open_hit = frog & (|open_vec);
  assign dup_hit  = frog & (|(end_zone & slots_filled));
  assign dly_en   = (state == DYING) || (state == SCORED);

  frame_counter #(.TERM(RESPAWN_FRAMES)) u_dly (
    .clk   (clk),
    .rst   (rst),
    .clr   (!dly_en),
    .en    (dly_en),
    .tick  (frame_tick),
    .count (unused_dly_cnt),
    .done  (dly_done)
  );

`ifdef FROG_TIMER_EN
  localparam int TW = cnt_w(TIME_FRAMES);
  logic          alive, timeout;
  logic [TW-1:0] tmr_cnt;

  assign alive = (state == ALIVE);

  // Held clear outside ALIVE, so each life starts from a fresh budget.
  frame_counter #(.TERM(TIME_FRAMES)) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (!alive),
    .en    (alive),
    .tick  (frame_tick),
    .count (tmr_cnt),
    .done  (timeout)
  );

  assign time_left = TW'(TIME_FRAMES) - tmr_cnt;
  assign death     = squish | dup_hit | timeout;
`else
  localparam int unused_time_frames = TIME_FRAMES;
  assign death = squish | dup_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ALIVE;
      lives        <= LW'(LIVES);
      slots_filled <= '0;
      hit          <= 1'b0;
      score_pulse  <= 1'b0;
      respawn      <= 1'b0;
      win          <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      lives        <= lives_n;
      slots_filled <= slots_n;
      hit          <= hit_n;
      score_pulse  <= score_n;
      respawn      <= resp_n;
      win          <= (state_n == WON);
      game_over    <= (state_n == LOST);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ALIVE: begin
        if (open_hit)   state_n = (&(slots_filled | low_slot)) ? WON : SCORED;
        else if (death) state_n = (lives == LW'(1)) ? LOST : DYING;
      end
      DYING, SCORED: if (dly_done) state_n = ALIVE;
      default:       state_n = state;
    endcase
  end

  always_comb begin
    lives_n = lives;
    slots_n = slots_filled;
    hit_n   = 1'b0;
    score_n = 1'b0;
    resp_n  = 1'b0;
    case (state)
      ALIVE: begin
        if (open_hit) begin
          slots_n = slots_filled | low_slot;
          score_n = 1'b1;
        end else if (death) begin
          hit_n   = 1'b1;
          lives_n = lives - LW'(1);
        end
      end
      DYING, SCORED: resp_n = dly_done;
      LOST:          lives_n = '0;
      default:       ;
    endcase
  end

endmodule
